nx_fifo_srfram_mc: RTL
======================

// Module: nx_fifo_srfram_mc
// PURPOSE
//  Multi-channel FIFO: N_CH independent logical queues in one shared 1R1W sync-read RAM.
//  Each channel owns a fixed region [ch*N_ENTRIES +: N_ENTRIES].
//  Used where several engine streams share one buffer macro instead of one FIFO per stream.
//  Adds per-channel status, programmable almost-full, sticky errors with masked clear,
//  and non-power-of-2 depth.
// PARAMETERS
//  N_CH          4   number of logical channels (>=1)
//  N_DATA_BITS  32   data width
//  N_ENTRIES    12   entries per channel (>=2; need not be a power of 2)
//  AFULL_BITS    4   width of almost-full threshold input
// PORTS
//  clk            in   1                 clock
//  rst_n          in   1                 async active-low reset
//  wr             in   1                 push request
//  wr_ch          in   log2(N_CH)        push channel
//  wr_data        in   N_DATA_BITS       push data
//  rd             in   1                 pop request
//  rd_ch          in   log2(N_CH)        pop channel
//  rd_valid       out  1                 rd_data valid (1 cycle after accepted pop)
//  rd_data        out  N_DATA_BITS       popped data
//  rd_data_ch     out  log2(N_CH)        channel of rd_data
//  empty          out  N_CH              per-channel depth==0
//  full           out  N_CH              per-channel depth==N_ENTRIES
//  afull          out  N_CH              per-channel depth>=afull_thresh
//  afull_thresh   in   AFULL_BITS        almost-full level, shared by all channels
//  depth          out  N_CH*log2(N_ENTRIES+1)  packed per-channel occupancy
//  ovf            out  N_CH              sticky: push to full channel
//  unf            out  N_CH              sticky: pop from empty channel
//  err_clr        in   N_CH              one-cycle pulse mask; clears ovf/unf bits
//  hwm            out  N_CH*log2(N_ENTRIES+1)  per-channel high-water mark (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all pointers, depths, ovf, unf, hwm, rd_valid, rd_data, rd_data_ch = 0;
//    empty = all 1s; full = afull = 0.
//  - Push is accepted iff wr && !full[wr_ch] (full as registered at cycle start).
//    An accepted push writes RAM[wr_ch*N_ENTRIES + wptr[wr_ch]] at the clock edge.
//    wptr increments and wraps N_ENTRIES-1 -> 0.
//  - Rejected push: RAM and pointers unchanged; ovf[wr_ch] <= 1.
//  - Pop is accepted iff rd && !empty[rd_ch]. The RAM read address is issued the same cycle.
//    Next cycle: rd_valid=1, rd_data = entry, rd_data_ch = rd_ch.
//    rptr increments and wraps as for wptr.
//  - Rejected pop: no RAM read; rd_valid=0 next cycle; unf[rd_ch] <= 1.
//  - When rd_valid=0, rd_data and rd_data_ch hold their last value.
//  - depth[ch] next = depth + push_acc(ch) - pop_acc(ch).
//    Simultaneous accepted push and pop on the same channel: depth unchanged, both pointers advance.
//    Push and pop on different channels are fully independent.
//  - Written data is poppable from the cycle after the push, with no bypass.
//    Same-address read/write in one cycle cannot occur: it would need a pop of an empty or
//    push to a full channel, and both are rejected.
//  - empty, full and afull are registered, derived from next-state depth.
//    Push-then-pop throughput per channel is 1 per cycle.
//  - afull_thresh=0 forces afull all 1s. afull_thresh>N_ENTRIES forces afull all 0s.
//  - err_clr has priority over a same-cycle set on the same bit (clear wins).
//  - Reset asserted mid-operation: all state returns to reset values at once.
//    Any in-flight rd_valid is dropped. RAM contents are don't-care.
// CONFIGURATION
//  - NX_FIFO_SRFRAM_MC_HWM_EN defined:
//    hwm[ch] <= max(hwm[ch], depth_next[ch]) every cycle.
//    err_clr[ch] also resets hwm[ch] to the current depth[ch].
//  - Macro undefined: hwm tied to 0 and no HWM flops are synthesised.
// TESTING
//  1. N_CH=4, N_ENTRIES=12: push 12 words (0xA0..0xAB) to ch2
//     -> full[2]=1, depth[2]=12, other channels empty.
//     13th push -> ovf[2]=1, data unchanged.
//  2. Pop ch2 x12 -> rd_data 0xA0..0xAB, each 1 cycle after its pop, rd_data_ch=2.
//     Then empty[2]=1; one extra pop -> unf[2]=1, rd_valid=0.
//  3. Wrap test: push/pop ch0 alternately for 30 words -> in-order data, across pointer wrap 11->0.
//  4. Same-cycle push ch1 + pop ch1 at depth=5 -> depth stays 5 for 8 cycles, data in order.
//     Push ch3 + pop ch0 -> depth[3]+1, depth[0]-1.
//  5. afull_thresh=9: 9th push to ch1 -> afull[1] rises the cycle after.
//     err_clr=4'b0100 in the same cycle as an overflow on ch2 -> ovf[2]=0.
//  6. HWM_EN: fill ch3 to 7, drain to 2 -> hwm[3]=7; err_clr[3] -> hwm[3]=2.
//     Reset mid-burst -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/nx_fifo_srfram_mc.sv
// Multi-channel FIFO: N_CH logical queues sharing one 1R1W sync-read RAM, fixed region per channel.
// Optional high-water-mark tracking is enabled by defining NX_FIFO_SRFRAM_MC_HWM_EN.
module nx_fifo_srfram_mc #(
    parameter int N_CH        = 4,
    parameter int N_DATA_BITS = 32,
    parameter int N_ENTRIES   = 12,
    parameter int AFULL_BITS  = 4,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int DEP_W = $clog2(N_ENTRIES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [N_DATA_BITS-1:0]  wr_data,
    input  logic                    rd,
    input  logic [CH_W-1:0]         rd_ch,
    output logic                    rd_valid,
    output logic [N_DATA_BITS-1:0]  rd_data,
    output logic [CH_W-1:0]         rd_data_ch,
    output logic [N_CH-1:0]         empty,
    output logic [N_CH-1:0]         full,
    output logic [N_CH-1:0]         afull,
    input  logic [AFULL_BITS-1:0]   afull_thresh,
    output logic [N_CH*DEP_W-1:0]   depth,
    output logic [N_CH-1:0]         ovf,
    output logic [N_CH-1:0]         unf,
    input  logic [N_CH-1:0]         err_clr,
    output logic [N_CH*DEP_W-1:0]   hwm
);

    localparam int PTR_W     = $clog2(N_ENTRIES);
    localparam int RAM_DEPTH = N_CH * N_ENTRIES;
    localparam int AW        = $clog2(RAM_DEPTH);
    localparam bit CH_POW2   = ((1 << CH_W) == N_CH);

    logic [N_DATA_BITS-1:0] mem_r [RAM_DEPTH];
    logic [PTR_W-1:0]       wptr_r [N_CH];
    logic [PTR_W-1:0]       rptr_r [N_CH];
    logic [DEP_W-1:0]       depth_r [N_CH];
    logic [DEP_W-1:0]       depth_nxt_s [N_CH];
    logic [N_CH-1:0]        empty_r, full_r, afull_r, ovf_r, unf_r;
    logic [N_CH-1:0]        empty_nxt_s, full_nxt_s, afull_nxt_s, ovf_nxt_s, unf_nxt_s;
    logic [N_CH-1:0]        push_ch_s, pop_ch_s;
    logic                   wr_ch_ok_s, rd_ch_ok_s;
    logic                   push_acc_s, pop_acc_s;
    logic [AW-1:0]          waddr_s, raddr_s;
    logic                   rd_valid_r;
    logic [N_DATA_BITS-1:0] rd_data_r;
    logic [CH_W-1:0]        rd_data_ch_r;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(N_ENTRIES - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Channel numbers beyond N_CH only exist when N_CH is not a power of two
    if (CH_POW2) begin : g_ch_pow2
        assign wr_ch_ok_s = 1'b1;
        assign rd_ch_ok_s = 1'b1;
    end else begin : g_ch_npow2
        assign wr_ch_ok_s = (wr_ch < CH_W'(N_CH));
        assign rd_ch_ok_s = (rd_ch < CH_W'(N_CH));
    end

    assign push_acc_s = wr && wr_ch_ok_s && !full_r[wr_ch];
    assign pop_acc_s  = rd && rd_ch_ok_s && !empty_r[rd_ch];
    assign waddr_s    = AW'(int'(wr_ch) * N_ENTRIES + int'(wptr_r[wr_ch]));
    assign raddr_s    = AW'(int'(rd_ch) * N_ENTRIES + int'(rptr_r[rd_ch]));

    // Per-channel next-state occupancy, flags and sticky errors (clear beats set)
    always_comb begin
        push_ch_s   = {N_CH{1'b0}};
        pop_ch_s    = {N_CH{1'b0}};
        empty_nxt_s = {N_CH{1'b1}};
        full_nxt_s  = {N_CH{1'b0}};
        afull_nxt_s = {N_CH{1'b0}};
        ovf_nxt_s   = {N_CH{1'b0}};
        unf_nxt_s   = {N_CH{1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            push_ch_s[c] = push_acc_s && (wr_ch == CH_W'(c));
            pop_ch_s[c]  = pop_acc_s && (rd_ch == CH_W'(c));
            case ({push_ch_s[c], pop_ch_s[c]})
                2'b10:   depth_nxt_s[c] = depth_r[c] + DEP_W'(1);
                2'b01:   depth_nxt_s[c] = depth_r[c] - DEP_W'(1);
                default: depth_nxt_s[c] = depth_r[c];
            endcase
            empty_nxt_s[c] = (depth_nxt_s[c] == {DEP_W{1'b0}});
            full_nxt_s[c]  = (depth_nxt_s[c] == DEP_W'(N_ENTRIES));
            afull_nxt_s[c] = (32'(depth_nxt_s[c]) >= 32'(afull_thresh));
            if (err_clr[c]) begin
                ovf_nxt_s[c] = 1'b0;
                unf_nxt_s[c] = 1'b0;
            end else begin
                ovf_nxt_s[c] = ovf_r[c] | (wr && full_r[c] && (wr_ch == CH_W'(c)));
                unf_nxt_s[c] = unf_r[c] | (rd && empty_r[c] && (rd_ch == CH_W'(c)));
            end
        end
    end

    // Pointer, occupancy and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                wptr_r[c]  <= {PTR_W{1'b0}};
                rptr_r[c]  <= {PTR_W{1'b0}};
                depth_r[c] <= {DEP_W{1'b0}};
            end
            empty_r <= {N_CH{1'b1}};
            full_r  <= {N_CH{1'b0}};
            afull_r <= {N_CH{1'b0}};
            ovf_r   <= {N_CH{1'b0}};
            unf_r   <= {N_CH{1'b0}};
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                depth_r[c] <= depth_nxt_s[c];
            end
            if (push_acc_s) begin
                wptr_r[wr_ch] <= ptr_inc(wptr_r[wr_ch]);
            end
            if (pop_acc_s) begin
                rptr_r[rd_ch] <= ptr_inc(rptr_r[rd_ch]);
            end
            empty_r <= empty_nxt_s;
            full_r  <= full_nxt_s;
            afull_r <= afull_nxt_s;
            ovf_r   <= ovf_nxt_s;
            unf_r   <= unf_nxt_s;
        end
    end

    // Shared storage array, no reset so it maps onto a RAM macro
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_r[waddr_s] <= wr_data;
        end
    end

    // Synchronous read port; data and channel hold while no pop is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r   <= 1'b0;
            rd_data_r    <= {N_DATA_BITS{1'b0}};
            rd_data_ch_r <= {CH_W{1'b0}};
        end else begin
            rd_valid_r <= pop_acc_s;
            if (pop_acc_s) begin
                rd_data_r    <= mem_r[raddr_s];
                rd_data_ch_r <= rd_ch;
            end
        end
    end

    // Pack per-channel occupancy onto the flat output bus
    always_comb begin
        depth = {(N_CH*DEP_W){1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            depth[c*DEP_W +: DEP_W] = depth_r[c];
        end
    end

`ifdef NX_FIFO_SRFRAM_MC_HWM_EN
    logic [DEP_W-1:0] hwm_r [N_CH];

    // High-water mark tracks peak next-state depth; err_clr rebases it to the current depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                hwm_r[c] <= {DEP_W{1'b0}};
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (err_clr[c]) begin
                    hwm_r[c] <= depth_r[c];
                end else if (depth_nxt_s[c] > hwm_r[c]) begin
                    hwm_r[c] <= depth_nxt_s[c];
                end
            end
        end
    end

    // Pack high-water marks onto the flat output bus
    always_comb begin
        hwm = {(N_CH*DEP_W){1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            hwm[c*DEP_W +: DEP_W] = hwm_r[c];
        end
    end
`else
    assign hwm = {(N_CH*DEP_W){1'b0}};
`endif

    assign rd_valid   = rd_valid_r;
    assign rd_data    = rd_data_r;
    assign rd_data_ch = rd_data_ch_r;
    assign empty      = empty_r;
    assign full       = full_r;
    assign afull      = afull_r;
    assign ovf        = ovf_r;
    assign unf        = unf_r;

endmodule
